// File: rtl/clm_host_driver_if.sv
// -----------------------------------------------------------------------------
// clm_host_driver_if
// Handshake bundle between the host driver and the cipher framework.
//   Kin  [127:0] key presented to the framework
//   Din  [511:0] packed mask words, mask-select field and plaintext
//   Krdy         key-ready pulse
//   Drdy         data-ready pulse
//   EN           framework enable
//   Kvld         framework accepted the key
//   Dvld         framework result valid
//   Dout [127:0] framework result
//   BSY          framework busy (informational only)
// master: the host driver side.  slave: the framework side.
// -----------------------------------------------------------------------------
interface clm_host_driver_if;
    logic [127:0] Kin;
    logic [511:0] Din;
    logic         Krdy;
    logic         Drdy;
    logic         EN;
    logic         Kvld;
    logic         Dvld;
    logic [127:0] Dout;
    logic         BSY;

    modport master (
        output Kin, Din, Krdy, Drdy, EN,
        input  Kvld, Dvld, Dout, BSY
    );

    modport slave (
        input  Kin, Din, Krdy, Drdy, EN,
        output Kvld, Dvld, Dout, BSY
    );
endinterface

// File: rtl/clm_host_driver.sv
// -----------------------------------------------------------------------------
// clm_host_driver
// Drives one masked encryption through the cipher framework: draws 23 random
// mask words from a 32-bit LFSR, presents the key, then the packed data word,
// and captures the result (or reports a handshake timeout).
//
// Parameters
//   D        width of each random mask word (1..16)
//   TIMEOUT  maximum cycles spent waiting in KWAIT or DWAIT (1..1023)
//
// Ports
//   CLK, RSTn      clock, asynchronous active-low reset
//   seed_load      load seed_i into the LFSR (zero seed is replaced by 1)
//   seed_i         LFSR seed
//   req_i          start one encryption (sampled in IDLE only)
//   pt_i/key_i/p_i plaintext, key, mask-select field (latched at start)
//   busy_o         high whenever the FSM is not in IDLE
//   done_o         one-cycle strobe, ct_o holds the new result
//   err_o          one-cycle strobe, a handshake phase timed out
//   ct_o           last captured ciphertext
//   fw             framework handshake (master side)
// -----------------------------------------------------------------------------
module clm_host_driver #(
    parameter int D       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              seed_load,
    input  logic [31:0]       seed_i,
    input  logic              req_i,
    input  logic [127:0]      pt_i,
    input  logic [127:0]      key_i,
    input  logic [4:0]        p_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [127:0]      ct_o,
    clm_host_driver_if.master fw
);

    localparam int         NWORDS    = 23;
    localparam logic [4:0] LAST_WORD = 5'(NWORDS - 1);
    localparam logic [9:0] TMO       = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RGEN,
        S_KEY,
        S_KWAIT,
        S_DATA,
        S_DWAIT
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [4:0]     rcnt_q, rcnt_d;
    logic [9:0]     wcnt_q, wcnt_d;
    logic [D-1:0]   r_q [NWORDS];
    logic [D-1:0]   r_d [NWORDS];
    logic [127:0]   pt_q, pt_d;
    logic [127:0]   key_q, key_d;
    logic [4:0]     p_q, p_d;
    logic           krdy_q, krdy_d;
    logic           drdy_q, drdy_d;
    logic           en_q, en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [127:0]   ct_q, ct_d;
    logic [127:0]   kin_q, kin_d;
    logic [511:0]   din_q, din_d;

    logic [31:0]    lfsr_step;
    logic [9:0]     wcnt_inc;
    logic           wait_expired;
    logic [511:0]   din_pack;
    logic           unused_bsy;

    // Framework busy carries no information this driver acts on.
    assign unused_bsy = fw.BSY;

    // Fibonacci LFSR, taps 32,22,2,1; shifts left, feedback enters at bit 0.
    assign lfsr_step = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    // The counter "reaches" TIMEOUT on the edge that would load it, so the
    // decision is made one cycle earlier; a valid in that cycle still wins.
    assign wcnt_inc     = wcnt_q + 10'd1;
    assign wait_expired = (wcnt_inc == TMO);

    // Word k sits with its MSB at bit 495-16k; unused bits stay zero.
    always_comb begin
        din_pack          = '0;
        din_pack[508:504] = p_q;
        for (int k = 0; k < NWORDS; k++) begin
            din_pack[495 - 16*k -: D] = r_q[k];
        end
        din_pack[127:0]   = pt_q;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        r_d     = r_q;
        pt_d    = pt_q;
        key_d   = key_q;
        p_d     = p_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // A seed load overrides the step; mid-RGEN the loaded value is
        // written straight into the current word.
        if (seed_load) begin
            lfsr_d = (seed_i == 32'd0) ? 32'h1 : seed_i;
        end else if (state_q == S_RGEN) begin
            lfsr_d = lfsr_step;
        end else begin
            lfsr_d = lfsr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_RGEN;
                    rcnt_d  = '0;
                    pt_d    = pt_i;
                    key_d   = key_i;
                    p_d     = p_i;
                end
            end
            S_RGEN: begin
                r_d[rcnt_q] = lfsr_d[D-1:0];
                rcnt_d      = rcnt_q + 5'd1;
                if (rcnt_q == LAST_WORD) state_d = S_KEY;
            end
            S_KEY: begin
                state_d = S_KWAIT;
                wcnt_d  = '0;
            end
            S_KWAIT: begin
                wcnt_d = wcnt_inc;
                if (fw.Kvld) begin
                    state_d = S_DATA;
                end else if (wait_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_DATA: begin
                state_d = S_DWAIT;
                wcnt_d  = '0;
            end
            S_DWAIT: begin
                wcnt_d = wcnt_inc;
                if (fw.Dvld) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ct_d    = fw.Dout;
                end else if (wait_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies
        // line up exactly with the state they describe.
        krdy_d = (state_d == S_KEY);
        drdy_d = (state_d == S_DATA);
        en_d   = (state_d == S_KEY)  || (state_d == S_KWAIT) ||
                 (state_d == S_DATA) || (state_d == S_DWAIT);
        busy_d = (state_d != S_IDLE);
        kin_d  = en_d ? key_q : '0;

        if (state_d == S_DATA) begin
            din_d = din_pack;
        end else if (state_d == S_DWAIT) begin
            din_d = din_q;
        end else begin
            din_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            lfsr_q  <= 32'h1;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            // NOTE: the mask-word store is reset as well, so nothing from an
            // aborted operation can reappear on Din afterwards.
            for (int k = 0; k < NWORDS; k++) begin
                r_q[k] <= '0;
            end
            pt_q    <= '0;
            key_q   <= '0;
            p_q     <= '0;
            krdy_q  <= 1'b0;
            drdy_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ct_q    <= '0;
            kin_q   <= '0;
            din_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the same pre-edge state.
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
            r_q     <= r_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            p_q     <= p_d;
            krdy_q  <= krdy_d;
            drdy_q  <= drdy_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ct_q    <= ct_d;
            kin_q   <= kin_d;
            din_q   <= din_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign ct_o    = ct_q;
    assign fw.Kin  = kin_q;
    assign fw.Din  = din_q;
    assign fw.Krdy = krdy_q;
    assign fw.Drdy = drdy_q;
    assign fw.EN   = en_q;

endmodule

// File: tb/tb_clm_host_driver.sv
// -----------------------------------------------------------------------------
// tb_clm_host_driver
// Directed bench for clm_host_driver. Two instances (D=8 and D=3, both with
// TIMEOUT=16) share host inputs and responder timing and run in lockstep.
// Each step samples at the falling edge plus 1 time unit.
// -----------------------------------------------------------------------------
module tb_clm_host_driver;

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         seed_load;
    logic [31:0]  seed_i;
    logic         req_i;
    logic [127:0] pt_i, key_i;
    logic [4:0]   p_i;
    logic         busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [127:0] ct_a, ct_b;

    // responder controls
    int           k_dly, d_dly;
    logic [127:0] dout_v;
    logic         resp_kvld = 1'b0, resp_dvld = 1'b0;
    logic         spur_kvld, spur_dvld;

    // observations gathered by the responder
    int           n_krdy = 0, n_drdy = 0, n_done = 0, n_err = 0;
    int           kt = -1, dt = -1;
    logic [511:0] din_cap_a = '0, din_cap_b = '0, din_late = '0;
    logic [127:0] kin_cap = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clm_host_driver_if if_a ();
    clm_host_driver_if if_b ();

    assign if_a.Kvld = resp_kvld | spur_kvld;
    assign if_a.Dvld = resp_dvld | spur_dvld;
    assign if_a.Dout = dout_v;
    assign if_a.BSY  = 1'b1;
    assign if_b.Kvld = resp_kvld | spur_kvld;
    assign if_b.Dvld = resp_dvld | spur_dvld;
    assign if_b.Dout = dout_v;
    assign if_b.BSY  = 1'b1;

    clm_host_driver #(.D(8), .TIMEOUT(16)) dut_a (
        .CLK(clk), .RSTn(rst_n), .seed_load(seed_load), .seed_i(seed_i),
        .req_i(req_i), .pt_i(pt_i), .key_i(key_i), .p_i(p_i),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .ct_o(ct_a),
        .fw(if_a)
    );

    clm_host_driver #(.D(3), .TIMEOUT(16)) dut_b (
        .CLK(clk), .RSTn(rst_n), .seed_load(seed_load), .seed_i(seed_i),
        .req_i(req_i), .pt_i(pt_i), .key_i(key_i), .p_i(p_i),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .ct_o(ct_b),
        .fw(if_b)
    );

    // Responder: Kvld is sampled k_dly edges after the edge that raised Krdy,
    // Dvld d_dly edges after the edge that raised Drdy (d_dly=0: never).
    always @(negedge clk) begin
        if (if_a.Krdy) begin
            n_krdy++;
            kin_cap = if_a.Kin;
            kt = 0;
        end else if (kt >= 0) begin
            kt++;
        end
        if (if_a.Drdy) begin
            n_drdy++;
            din_cap_a = if_a.Din;
            din_cap_b = if_b.Din;
            dt = 0;
        end else if (dt >= 0) begin
            dt++;
        end
        if (done_a) n_done++;
        if (err_a)  n_err++;

        resp_kvld = 1'b0;
        resp_dvld = 1'b0;
        if (k_dly > 0 && kt == k_dly - 1) begin
            resp_kvld = 1'b1;
            kt = -1;
        end
        if (d_dly > 0 && dt == d_dly - 1) begin
            resp_dvld = 1'b1;
            din_late = if_a.Din;
            dt = -1;
        end
        if (!busy_a) begin
            kt = -1;
            dt = -1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    // Expected Din after 23 LFSR steps from the given state.
    function automatic logic [511:0] exp_din(input logic [31:0] seed, input logic [4:0] p,
                                             input logic [127:0] pt, input int d);
        logic [511:0] v;
        logic [31:0]  s;
        v = '0;
        s = seed;
        for (int i = 0; i < 5; i++) v[504 + i] = p[i];
        for (int k = 0; k < 23; k++) begin
            s = lfsr_next(s);
            for (int b = 0; b < d; b++) v[495 - 16*k - d + 1 + b] = s[b];
        end
        v[127:0] = pt;
        return v;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done_o or err_o.
    // lat counts steps from the first RGEN cycle to the strobe.
    task automatic do_op(input logic [127:0] pt, input logic [127:0] key, input logic [4:0] p,
                         input int kd, input int dd, input logic [127:0] dout, output int lat);
        k_dly  = kd;
        d_dly  = dd;
        dout_v = dout;
        req_i  = 1'b1;
        pt_i   = pt;
        key_i  = key;
        p_i    = p;
        step();
        req_i  = 1'b0;
        pt_i   = ~pt;
        key_i  = ~key;
        p_i    = ~p;
        check("rgen_busy", busy_a, 1'b1);
        check("rgen_en",   if_a.EN, 1'b0);
        check("rgen_kin",  if_a.Kin, '0);
        lat = 0;
        while (!(done_a || err_a) && lat < 200) begin
            step();
            lat++;
        end
        check("op_bound", lat < 200, 1'b1);
    endtask

    int lat;
    int k0, d0, n0, e0;

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed_i = '0; req_i = 1'b0;
        pt_i = '0; key_i = '0; p_i = '0;
        k_dly = 2; d_dly = 5; dout_v = '0; spur_kvld = 1'b0; spur_dvld = 1'b0;
        step();
        step();

        // reset state
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_err",  err_a, 1'b0);
        check("rst_ct",   ct_a, '0);
        check("rst_kin",  if_a.Kin, '0);
        check("rst_din",  if_a.Din, '0);
        check("rst_krdy", if_a.Krdy, 1'b0);
        check("rst_drdy", if_a.Drdy, 1'b0);
        check("rst_en",   if_a.EN, 1'b0);
        rst_n = 1'b1;
        step();

        // reference transaction, seed 1
        seed_i = 32'h1; seed_load = 1'b1; step(); seed_load = 1'b0;
        k0 = n_krdy; d0 = n_drdy; n0 = n_done; e0 = n_err;
        do_op(PT1, KEY1, 5'h13, 2, 5, CT1, lat);
        check("t1_lat",   lat, 30);
        check("t1_done",  done_a, 1'b1);
        check("t1_ct",    ct_a, CT1);
        check("t1_din_p", din_cap_a[508:504], 5'h13);
        check("t1_din_pt", din_cap_a[127:0], PT1);
        check("t1_din_a", din_cap_a, exp_din(32'h1, 5'h13, PT1, 8));
        check("t1_din_b", din_cap_b, exp_din(32'h1, 5'h13, PT1, 3));
        check("t1_din_hold", din_late, din_cap_a);
        check("t1_kin",   kin_cap, KEY1);
        step();
        check("t1_done_pulse", done_a, 1'b0);
        check("t1_idle",  busy_a, 1'b0);
        check("t1_krdy_n", n_krdy - k0, 1);
        check("t1_drdy_n", n_drdy - d0, 1);
        check("t1_done_n", n_done - n0, 1);
        check("t1_err_n",  n_err - e0, 0);

        // zero seed loads 1
        seed_i = 32'h0; seed_load = 1'b1; step(); seed_load = 1'b0;
        do_op(~PT1, KEY1 ^ 128'h5a, 5'h0a, 3, 4, 128'h1234, lat);
        check("t2_lat",   lat, 30);
        check("t2_din_a", din_cap_a, exp_din(32'h1, 5'h0a, ~PT1, 8));
        check("t2_din_b", din_cap_b, exp_din(32'h1, 5'h0a, ~PT1, 3));
        check("t2_ct",    ct_a, 128'h1234);
        step();

        // arbitrary seed
        seed_i = 32'hC0FFEE11; seed_load = 1'b1; step(); seed_load = 1'b0;
        do_op(PT1 ^ KEY1, KEY1, 5'h1f, 4, 2, 128'h5555, lat);
        check("t3_lat",   lat, 29);
        check("t3_din_a", din_cap_a, exp_din(32'hC0FFEE11, 5'h1f, PT1 ^ KEY1, 8));
        check("t3_din_b", din_cap_b, exp_din(32'hC0FFEE11, 5'h1f, PT1 ^ KEY1, 3));
        check("t3_ct",    ct_a, 128'h5555);
        step();

        // Dvld never arrives: err 16 cycles after DWAIT entry
        n0 = n_done; e0 = n_err;
        do_op(PT1, KEY1, 5'h01, 2, 0, 128'hbad0, lat);
        check("t4_lat",   lat, 42);
        check("t4_err",   err_a, 1'b1);
        check("t4_done",  done_a, 1'b0);
        check("t4_idle",  busy_a, 1'b0);
        check("t4_ct",    ct_a, 128'h5555);
        step();
        check("t4_err_pulse", err_a, 1'b0);
        check("t4_err_n",  n_err - e0, 1);
        check("t4_done_n", n_done - n0, 0);

        // Dvld coincides with the timeout decision: valid wins
        e0 = n_err;
        do_op(PT1, KEY1, 5'h02, 2, 17, 128'hc0de, lat);
        check("t5_lat",   lat, 42);
        check("t5_done",  done_a, 1'b1);
        check("t5_err",   err_a, 1'b0);
        check("t5_ct",    ct_a, 128'hc0de);
        step();
        check("t5_err_n", n_err - e0, 0);

        // Dvld one cycle late: timeout, late Dvld lands in IDLE and is ignored
        n0 = n_done;
        do_op(PT1, KEY1, 5'h03, 2, 18, 128'hdead, lat);
        check("t5b_lat",  lat, 42);
        check("t5b_err",  err_a, 1'b1);
        step();
        step();
        check("t5b_ct",     ct_a, 128'hc0de);
        check("t5b_done_n", n_done - n0, 0);

        // reset during DWAIT
        k_dly = 2; d_dly = 0;
        req_i = 1'b1; pt_i = PT1; key_i = KEY1; p_i = 5'h04;
        step();
        req_i = 1'b0;
        repeat (27) step();
        check("t6_en_dwait",   if_a.EN, 1'b1);
        check("t6_busy_dwait", busy_a, 1'b1);
        n0 = n_done; e0 = n_err;
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy_a, 1'b0);
        check("t6_en",   if_a.EN, 1'b0);
        check("t6_kin",  if_a.Kin, '0);
        check("t6_din",  if_a.Din, '0);
        check("t6_ct",   ct_a, '0);
        check("t6_krdy", if_a.Krdy, 1'b0);
        check("t6_drdy", if_a.Drdy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t6_done_n", n_done - n0, 0);
        check("t6_err_n",  n_err - e0, 0);
        do_op(KEY1, PT1, 5'h15, 2, 5, 128'h7777, lat);
        check("t6_lat",   lat, 30);
        check("t6_ct2",   ct_a, 128'h7777);
        check("t6_din_a", din_cap_a, exp_din(32'h1, 5'h15, KEY1, 8));
        step();

        // spurious Kvld/Dvld in IDLE are ignored
        n0 = n_done;
        dout_v = 128'hffff; spur_kvld = 1'b1; spur_dvld = 1'b1;
        step();
        step();
        spur_kvld = 1'b0; spur_dvld = 1'b0;
        check("t7_spur_busy", busy_a, 1'b0);
        check("t7_spur_ct",   ct_a, 128'h7777);
        check("t7_spur_done", n_done - n0, 0);

        // req_i held across done_o: back-to-back operations
        k0 = n_krdy; d0 = n_drdy; n0 = n_done; e0 = n_err;
        k_dly = 2; d_dly = 5; dout_v = 128'h8888;
        req_i = 1'b1; pt_i = PT1; key_i = KEY1; p_i = 5'h06;
        step();
        lat = 0;
        while (!done_a && lat < 200) begin step(); lat++; end
        check("t7_lat1", lat, 30);
        step();
        req_i = 1'b0;
        check("t7_restart", busy_a, 1'b1);
        lat = 0;
        while (!done_a && lat < 200) begin step(); lat++; end
        check("t7_lat2", lat, 30);
        step();
        check("t7_idle",   busy_a, 1'b0);
        check("t7_krdy_n", n_krdy - k0, 2);
        check("t7_drdy_n", n_drdy - d0, 2);
        check("t7_done_n", n_done - n0, 2);
        check("t7_err_n",  n_err - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
